// File: rtl/keypad_pkg.sv
// Shared types, key map and small decode helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        KP_NONE  = 2'd0,
        KP_KEY   = 2'd1,
        KP_GHOST = 2'd2
    } kp_frame_t;

    // Indexed {row, col}; Pmod KYPD layout.
    localparam logic [3:0] KEY_MAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // Number of low rows in one sample, saturated at 2 (2 means "several").
    function automatic logic [1:0] kp_low_count(input logic [3:0] low);
        case (low)
            4'b0000:                            kp_low_count = 2'd0;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: kp_low_count = 2'd1;
            default:                            kp_low_count = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] kp_row_index(input logic [3:0] low);
        case (low)
            4'b0001: kp_row_index = 2'd0;
            4'b0010: kp_row_index = 2'd1;
            4'b0100: kp_row_index = 2'd2;
            4'b1000: kp_row_index = 2'd3;
            default: kp_row_index = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_hex_in_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_hex_in.sv
// 4x4 hex keypad scanner/debouncer with valid/ready key events and an 8-digit history.
// Optional autorepeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_hex_in
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W      = 10,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    input  logic        key_ready,
    output logic        overrun,
    input  logic        clear,
    output logic [31:0] value
);

    localparam logic [3:0] DB_N = 4'(DEBOUNCE_FRAMES);

    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_hex_in: parameter out of range");
    end

    logic [SCAN_DIV_W-1:0] div_q;
    logic [1:0]            cidx_q;
    logic [3:0]            col_q;
    logic [1:0]            acc_cnt_q;
    logic [3:0]            acc_key_q;
    logic [3:0]            row_sync_s;
    logic [3:0]            row_low_s;
    logic                  slot_end_s;
    logic                  frame_end_s;
    logic [1:0]            slot_cnt_s;
    logic [2:0]            sum_s;
    logic [1:0]            frame_cnt_s;
    logic [3:0]            frame_idx_s;
    logic [3:0]            frame_code_s;
    kp_frame_t             frame_s;

    kp_state_t             state_q, state_d;
    logic [3:0]            cand_q, cand_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  fsm_emit_s;
    logic                  rep_emit_s;
    logic                  emit_s;
    logic                  key_valid_q;
    logic [3:0]            key_code_q;
    logic                  overrun_q;
    logic [31:0]           value_q;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (row),
        .q_o   (row_sync_s)
    );

    assign row_low_s   = ~row_sync_s;
    assign slot_end_s  = &div_q;
    assign frame_end_s = slot_end_s & (cidx_q == 2'd3);
    assign slot_cnt_s  = kp_low_count(row_low_s);

    // Fold this slot's sample into the running frame tally.
    always_comb begin
        sum_s = {1'b0, acc_cnt_q} + {1'b0, slot_cnt_s};
        if (sum_s >= 3'd2) begin
            frame_cnt_s = 2'd2;
        end else begin
            frame_cnt_s = sum_s[1:0];
        end
        if (slot_cnt_s == 2'd1) begin
            frame_idx_s = {kp_row_index(row_low_s), cidx_q};
        end else begin
            frame_idx_s = acc_key_q;
        end
        case (frame_cnt_s)
            2'd0:    frame_s = KP_NONE;
            2'd1:    frame_s = KP_KEY;
            default: frame_s = KP_GHOST;
        endcase
        frame_code_s = KEY_MAP[frame_idx_s];
    end

    // Column scan timing and per-frame row accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            cidx_q    <= 2'd0;
            col_q     <= 4'b1110;
            acc_cnt_q <= 2'd0;
            acc_key_q <= 4'd0;
        end else begin
            div_q <= div_q + SCAN_DIV_W'(1);
            if (slot_end_s) begin
                cidx_q <= cidx_q + 2'd1;
                col_q  <= ~(4'b0001 << (cidx_q + 2'd1));
                if (frame_end_s) begin
                    acc_cnt_q <= 2'd0;
                    acc_key_q <= 4'd0;
                end else begin
                    acc_cnt_q <= frame_cnt_s;
                    acc_key_q <= frame_idx_s;
                end
            end
        end
    end

    // Debounce state transitions, evaluated once per frame.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        fsm_emit_s = 1'b0;
        if (frame_end_s) begin
            case (state_q)
                IDLE: begin
                    if (frame_s == KP_KEY) begin
                        cand_d     = frame_code_s;
                        cnt_d      = 4'd1;
                        state_d    = (DB_N == 4'd1) ? HELD : PRESS_DB;
                        fsm_emit_s = (DB_N == 4'd1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESS_DB: begin
                    if (frame_s == KP_KEY && frame_code_s == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 >= DB_N) begin
                            state_d    = HELD;
                            fsm_emit_s = 1'b1;
                        end else begin
                            state_d = PRESS_DB;
                        end
                    end else if (frame_s == KP_KEY) begin
                        cand_d     = frame_code_s;
                        cnt_d      = 4'd1;
                        state_d    = (DB_N == 4'd1) ? HELD : PRESS_DB;
                        fsm_emit_s = (DB_N == 4'd1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (frame_s == KP_KEY) begin
                        state_d = HELD;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = (DB_N == 4'd1) ? IDLE : RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (frame_s == KP_KEY && frame_code_s == cand_q) begin
                        state_d = HELD;
                    end else if (frame_s == KP_KEY) begin
                        cand_d     = frame_code_s;
                        cnt_d      = 4'd1;
                        state_d    = (DB_N == 4'd1) ? HELD : PRESS_DB;
                        fsm_emit_s = (DB_N == 4'd1);
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = (cnt_q + 4'd1 >= DB_N) ? IDLE : RELEASE_DB;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(2 * REPEAT_FRAMES + 1);

    logic [REP_W-1:0] rep_q, rep_d;

    // Held-frame counter; zero outside HELD so every entry starts fresh.
    always_comb begin
        rep_d      = rep_q;
        rep_emit_s = 1'b0;
        if (state_q != HELD) begin
            rep_d = '0;
        end else if (frame_end_s && frame_s == KP_KEY) begin
            if (rep_q + REP_W'(1) == REP_W'(2 * REPEAT_FRAMES)) begin
                rep_d      = REP_W'(REPEAT_FRAMES);
                rep_emit_s = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end else begin
            rep_d = rep_q;
        end
    end

    // Autorepeat counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_emit_s = 1'b0;
`endif

    assign emit_s = fsm_emit_s | rep_emit_s;

    // FSM state plus registered event, overrun and history outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            overrun_q   <= 1'b0;
            value_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            if (clear) begin
                value_q <= 32'd0;
            end else if (emit_s) begin
                value_q <= {value_q[27:0], cand_d};
            end
            if (clear) begin
                overrun_q <= 1'b0;
            end else if (emit_s && key_valid_q && !key_ready) begin
                overrun_q <= 1'b1;
            end
            // An emit coinciding with an accept replaces the event instead of dropping it.
            if (emit_s) begin
                if (!key_valid_q || key_ready) begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= cand_d;
                end
            end else if (key_valid_q && key_ready) begin
                key_valid_q <= 1'b0;
            end
        end
    end

    assign col       = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign overrun   = overrun_q;
    assign value     = value_q;

endmodule
